// File: rtl/soc_bus_pkg.sv
// ---------------------------------------------------------------------------
// soc_bus_pkg
// Shared definitions for the picorv32 memory-port fabric:
//   - bus_state_t : transaction state (IDLE, ACC1, ACC2, RESP)
//   - ERR_DATA    : read data returned on unmapped or timed-out accesses
//   - cnt_width() : width of a counter that must hold 0..max_count
// ---------------------------------------------------------------------------
package soc_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC1 = 2'd1,
        ACC2 = 2'd2,
        RESP = 2'd3
    } bus_state_t;

    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/soc_bus_decoder.sv
// ---------------------------------------------------------------------------
// soc_bus_decoder
// Combinational address decoder. Compares the upper address bits against
// each slave base and returns a one-hot select. On overlapping bases the
// lowest slave index wins.
//
// SLAVE_BASE is written as a concatenation with slave 0 leftmost, so slave i
// lives at bit offset (N_SLAVES-1-i)*DECODE_BITS.
//
// Ports:
//   addr_top_i  in  DECODE_BITS  upper address bits (mem_addr[31 -: DECODE_BITS])
//   sel_o       out N_SLAVES     one-hot select, all zero when nothing matches
//   hit_o       out 1            at least one slave matched
// ---------------------------------------------------------------------------
module soc_bus_decoder
    import soc_bus_pkg::*;
#(
    parameter int                                N_SLAVES    = 6,
    parameter int                                DECODE_BITS = 8,
    parameter logic [N_SLAVES*DECODE_BITS-1:0]   SLAVE_BASE  = '0
) (
    input  logic [DECODE_BITS-1:0] addr_top_i,
    output logic [N_SLAVES-1:0]    sel_o,
    output logic                   hit_o
);

    logic found;

    always_comb begin
        sel_o = '0;
        found = 1'b0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (!found &&
                addr_top_i == SLAVE_BASE[(N_SLAVES-1-i)*DECODE_BITS +: DECODE_BITS]) begin
                sel_o[i] = 1'b1;
                found    = 1'b1;
            end
        end
        hit_o = found;
    end

endmodule

// File: rtl/soc_bus_fabric.sv
// ---------------------------------------------------------------------------
// soc_bus_fabric
// Routes the picorv32 native memory port to N memory-mapped slaves.
// Auto-ack slaves complete in a fixed 3 cycles (one cycle of read latency
// for synchronous RAMs); handshake slaves complete one cycle after their
// s_ready. Unmapped accesses return ERR_DATA and set a sticky error.
//
// Optional feature (macro SOC_BUS_TIMEOUT_EN): a wait counter aborts a
// handshake slave that has not answered within TIMEOUT_CYCLES cycles,
// returning ERR_DATA and recording an error.
//
// Handshake: the CPU holds mem_valid until it sees the one-cycle mem_ready
// pulse; the request is taken on the first cycle mem_valid is high in IDLE
// and runs to completion even if mem_valid drops. A slave is addressed while
// its s_valid bit is high; s_wstrb is non-zero only in the first select
// cycle; a handshake slave finishes by raising s_ready with valid s_rdata.
//
// Ports:
//   clk_cpu, reset            clock, async active-high reset
//   mem_valid/addr/wdata/wstrb CPU request (wstrb == 0 means read)
//   mem_ready, mem_rdata      registered completion pulse and read data
//   s_valid                   one-hot slave select
//   s_addr, s_wdata, s_wstrb  latched request towards the slaves
//   s_rdata, s_ready          slave read data (slave i at [32i +: 32]), ready
//   err_clr                   clears the sticky error
//   bus_err, err_addr         sticky error flag and first error address
//   dbg_state                 current transaction state
// All outputs are driven straight from flops.
// ---------------------------------------------------------------------------
module soc_bus_fabric
    import soc_bus_pkg::*;
#(
    parameter int                              N_SLAVES       = 6,
    parameter int                              DECODE_BITS    = 8,
    parameter logic [N_SLAVES*DECODE_BITS-1:0] SLAVE_BASE     = {8'h00, 8'h01, 8'hf0, 8'hfe, 8'hff, 8'h02},
    parameter logic [N_SLAVES-1:0]             SLAVE_AUTO_ACK = 6'b111110,
    parameter int                              TIMEOUT_CYCLES = 1023
) (
    input  logic                     clk_cpu,
    input  logic                     reset,
    input  logic                     mem_valid,
    input  logic [31:0]              mem_addr,
    input  logic [31:0]              mem_wdata,
    input  logic [3:0]               mem_wstrb,
    output logic                     mem_ready,
    output logic [31:0]              mem_rdata,
    output logic [N_SLAVES-1:0]      s_valid,
    output logic [31:0]              s_addr,
    output logic [31:0]              s_wdata,
    output logic [3:0]               s_wstrb,
    input  logic [N_SLAVES*32-1:0]   s_rdata,
    input  logic [N_SLAVES-1:0]      s_ready,
    input  logic                     err_clr,
    output logic                     bus_err,
    output logic [31:0]              err_addr,
    output bus_state_t               dbg_state
);

    bus_state_t          state_q;
    logic [N_SLAVES-1:0] sel_q;
    logic                mem_ready_q;
    logic [31:0]         mem_rdata_q;
    logic [N_SLAVES-1:0] s_valid_q;
    logic [31:0]         s_addr_q;
    logic [31:0]         s_wdata_q;
    logic [3:0]          s_wstrb_q;
    logic                bus_err_q, bus_err_d;
    logic [31:0]         err_addr_q, err_addr_d;

    logic [N_SLAVES-1:0] dec_sel;
    logic                dec_hit;
    logic [31:0]         sel_rdata;
    logic                sel_ready;
    logic                sel_auto;
    logic                tmo_fire;
    logic                err_event;

    soc_bus_decoder #(
        .N_SLAVES    (N_SLAVES),
        .DECODE_BITS (DECODE_BITS),
        .SLAVE_BASE  (SLAVE_BASE)
    ) u_decoder (
        .addr_top_i (mem_addr[31 -: DECODE_BITS]),
        .sel_o      (dec_sel),
        .hit_o      (dec_hit)
    );

    // One-hot AND-OR mux; sel_q is never multi-hot.
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            sel_rdata = sel_rdata | (s_rdata[32*i +: 32] & {32{sel_q[i]}});
        end
    end

    assign sel_ready = |(s_ready & sel_q);
    assign sel_auto  = |(SLAVE_AUTO_ACK & sel_q);

`ifdef SOC_BUS_TIMEOUT_EN
    localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic             hs_wait;

    assign hs_wait  = (state_q == ACC1 || state_q == ACC2) && !sel_auto;
    // cnt_q counts completed wait cycles; this cycle is the last one allowed.
    // A same-cycle s_ready takes priority over the abort.
    assign tmo_fire = hs_wait && !sel_ready && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Held at zero in IDLE, so every ACC1 starts counting from zero.
    always_ff @(posedge clk_cpu or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (state_q == IDLE) begin
            cnt_q <= '0;
        end else if (hs_wait && !sel_ready && !tmo_fire) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    logic [31:0] tmo_cfg_unused;

    assign tmo_cfg_unused = 32'(TIMEOUT_CYCLES);
    assign tmo_fire       = 1'b0;
`endif

    // Error recording: a new error beats a same-cycle clear, and only the
    // first error after a clear updates err_addr.
    assign err_event = ((state_q == IDLE) && mem_valid && !dec_hit) || tmo_fire;

    always_comb begin
        bus_err_d  = bus_err_q;
        err_addr_d = err_addr_q;
        if (err_clr) begin
            bus_err_d = 1'b0;
        end
        if (err_event && (!bus_err_q || err_clr)) begin
            bus_err_d  = 1'b1;
            err_addr_d = (state_q == IDLE) ? mem_addr : s_addr_q;
        end
    end

    always_ff @(posedge clk_cpu or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            mem_ready_q <= 1'b0;
            mem_rdata_q <= '0;
            s_valid_q   <= '0;
            s_addr_q    <= '0;
            s_wdata_q   <= '0;
            s_wstrb_q   <= '0;
            bus_err_q   <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            mem_ready_q <= 1'b0;
            bus_err_q   <= bus_err_d;
            err_addr_q  <= err_addr_d;
            case (state_q)
                IDLE: begin
                    if (mem_valid) begin
                        s_addr_q  <= mem_addr;
                        s_wdata_q <= mem_wdata;
                        sel_q     <= dec_sel;
                        if (dec_hit) begin
                            state_q   <= ACC1;
                            s_valid_q <= dec_sel;
                            s_wstrb_q <= mem_wstrb;
                        end else begin
                            state_q     <= RESP;
                            mem_ready_q <= 1'b1;
                            mem_rdata_q <= ERR_DATA;
                        end
                    end
                end
                ACC1: begin
                    // Strobes are presented for this single cycle only.
                    s_wstrb_q <= '0;
                    if (sel_auto) begin
                        state_q <= ACC2;
                    end else if (sel_ready) begin
                        state_q     <= RESP;
                        s_valid_q   <= '0;
                        mem_ready_q <= 1'b1;
                        mem_rdata_q <= sel_rdata;
                    end else if (tmo_fire) begin
                        state_q     <= RESP;
                        s_valid_q   <= '0;
                        mem_ready_q <= 1'b1;
                        mem_rdata_q <= ERR_DATA;
                    end else begin
                        state_q <= ACC2;
                    end
                end
                ACC2: begin
                    s_wstrb_q <= '0;
                    if (sel_auto || sel_ready) begin
                        state_q     <= RESP;
                        s_valid_q   <= '0;
                        mem_ready_q <= 1'b1;
                        mem_rdata_q <= sel_rdata;
                    end else if (tmo_fire) begin
                        state_q     <= RESP;
                        s_valid_q   <= '0;
                        mem_ready_q <= 1'b1;
                        mem_rdata_q <= ERR_DATA;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q   <= IDLE;
                    s_valid_q <= '0;
                end
            endcase
        end
    end

    assign mem_ready = mem_ready_q;
    assign mem_rdata = mem_rdata_q;
    assign s_valid   = s_valid_q;
    assign s_addr    = s_addr_q;
    assign s_wdata   = s_wdata_q;
    assign s_wstrb   = s_wstrb_q;
    assign bus_err   = bus_err_q;
    assign err_addr  = err_addr_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_soc_bus_fabric.sv
// ---------------------------------------------------------------------------
// tb_soc_bus_fabric
// Directed bench for soc_bus_fabric. Slave 1 is a RAM model with one cycle
// of read latency, slave 0 is a handshake slave driven by the tasks, the
// remaining slaves return fixed words. Inputs change and outputs are sampled
// on the falling edge. "n" below counts falling edges after the rising edge
// that accepts a request, so n == k means "visible at edge T+k".
// ---------------------------------------------------------------------------
module tb_soc_bus_fabric;
    import soc_bus_pkg::*;

    localparam int N = 6;

    logic            clk_cpu;
    logic            reset;
    logic            mem_valid;
    logic [31:0]     mem_addr;
    logic [31:0]     mem_wdata;
    logic [3:0]      mem_wstrb;
    logic            mem_ready;
    logic [31:0]     mem_rdata;
    logic [N-1:0]    s_valid;
    logic [31:0]     s_addr;
    logic [31:0]     s_wdata;
    logic [3:0]      s_wstrb;
    logic [N*32-1:0] s_rdata;
    logic [N-1:0]    s_ready;
    logic            err_clr;
    logic            bus_err;
    logic [31:0]     err_addr;
    bus_state_t      dbg_state;

    logic [31:0]     ram_q;
    logic [31:0]     hs_data;

    int checks = 0;
    int errors = 0;

    soc_bus_fabric #(.TIMEOUT_CYCLES(16)) dut (
        .clk_cpu   (clk_cpu),
        .reset     (reset),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .s_valid   (s_valid),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_rdata   (s_rdata),
        .s_ready   (s_ready),
        .err_clr   (err_clr),
        .bus_err   (bus_err),
        .err_addr  (err_addr),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk_cpu = 1'b0;
    always #5 clk_cpu = ~clk_cpu;

    // Synchronous RAM on slave 1: data appears the cycle after select.
    always @(posedge clk_cpu) ram_q <= s_valid[1] ? 32'h1234_5678 : 32'h0;

    assign s_rdata = {32'h5555_5555, 32'h4444_4444, 32'h3333_3333,
                      32'h2222_2222, ram_q, hs_data};

    // driver tasks
    task automatic start_req(input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] wstrb);
        @(negedge clk_cpu);
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
    endtask

    task automatic apply_reset();
        @(negedge clk_cpu);
        reset = 1'b1;
        @(negedge clk_cpu);
        @(negedge clk_cpu);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk_cpu);
        checks++;
        if ({mem_ready, s_valid, bus_err, s_wstrb} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%b s_valid=%b bus_err=%b s_wstrb=%b expected all 0",
                     mem_ready, s_valid, bus_err, s_wstrb);
        end
        checks++;
        if ({mem_rdata, s_addr, s_wdata, err_addr} !== '0) begin
            errors++;
            $display("FAIL reset_data: rdata=%h s_addr=%h s_wdata=%h err_addr=%h expected all 0",
                     mem_rdata, s_addr, s_wdata, err_addr);
        end
        checks++;
        if (dbg_state !== IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
        end
        reset = 1'b0;
    endtask

    // Also raises every s_ready: auto-ack and unselected slaves must ignore it.
    task automatic test_auto_read();
        logic [N-1:0] exp_v;
        s_ready = '1;
        start_req(32'h0100_0010, 32'h0, 4'b0000);
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk_cpu);
            if (n == 1) mem_valid = 1'b0;
            exp_v = (n <= 2) ? 6'b000010 : 6'b000000;
            checks++;
            if (s_valid !== exp_v || s_wstrb !== 4'b0000) begin
                errors++;
                $display("FAIL auto_read_sel n=%0d: s_valid=%b s_wstrb=%b expected %b 0000",
                         n, s_valid, s_wstrb, exp_v);
            end
            checks++;
            if (mem_ready !== (n == 3)) begin
                errors++;
                $display("FAIL auto_read_ready n=%0d: got %b expected %b", n, mem_ready, (n == 3));
            end
            if (n == 1) begin
                checks++;
                if (s_addr !== 32'h0100_0010) begin
                    errors++;
                    $display("FAIL auto_read_addr: got %h expected 01000010", s_addr);
                end
            end
            if (n == 3) begin
                checks++;
                if (mem_rdata !== 32'h1234_5678) begin
                    errors++;
                    $display("FAIL auto_read_data: got %h expected 12345678", mem_rdata);
                end
            end
        end
        s_ready = '0;
    endtask

    task automatic test_auto_write();
        logic [N-1:0] exp_v;
        logic [3:0]   exp_s;
        start_req(32'hFF00_0000, 32'h0000_002A, 4'b0001);
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk_cpu);
            if (n == 1) mem_valid = 1'b0;
            exp_v = (n <= 2) ? 6'b010000 : 6'b000000;
            exp_s = (n == 1) ? 4'b0001 : 4'b0000;
            checks++;
            if (s_valid !== exp_v || s_wstrb !== exp_s || mem_ready !== (n == 3)) begin
                errors++;
                $display("FAIL auto_write n=%0d: s_valid=%b s_wstrb=%b ready=%b expected %b %b %b",
                         n, s_valid, s_wstrb, mem_ready, exp_v, exp_s, (n == 3));
            end
            if (n == 1) begin
                checks++;
                if (s_wdata !== 32'h0000_002A) begin
                    errors++;
                    $display("FAIL auto_write_wdata: got %h expected 0000002a", s_wdata);
                end
            end
        end
    endtask

    // Handshake slave 0: ready raised during wait cycle `lat` (1 = in ACC1).
    task automatic run_handshake(input int lat, input logic [31:0] data, input string tag);
        start_req(32'h0000_0100, 32'h0, 4'b0000);
        for (int n = 1; n <= lat + 1; n++) begin
            @(negedge clk_cpu);
            if (n == 1) mem_valid = 1'b0;
            checks++;
            if (mem_ready !== (n == lat + 1) || s_valid[0] !== (n <= lat)) begin
                errors++;
                $display("FAIL %s n=%0d: ready=%b s_valid0=%b expected %b %b",
                         tag, n, mem_ready, s_valid[0], (n == lat + 1), (n <= lat));
            end
            if (n == lat) begin
                s_ready[0] = 1'b1;
                hs_data    = data;
            end
            if (n == lat + 1) begin
                s_ready[0] = 1'b0;
                hs_data    = 32'h0;
                checks++;
                if (mem_rdata !== data) begin
                    errors++;
                    $display("FAIL %s_data: got %h expected %h", tag, mem_rdata, data);
                end
            end
        end
    endtask

    task automatic test_handshake();
        run_handshake(5, 32'hCAFE_F00D, "hs_slow");
        run_handshake(1, 32'h0BAD_CAFE, "hs_fast");
    endtask

    task automatic err_req(input logic [31:0] addr, input logic clr,
                           input logic [31:0] exp_addr, input string tag);
        start_req(addr, 32'h0, 4'b0000);
        err_clr = clr;
        @(negedge clk_cpu);
        mem_valid = 1'b0;
        err_clr   = 1'b0;
        checks++;
        if (mem_ready !== 1'b1 || mem_rdata !== 32'hDEAD_BEEF || s_valid !== '0) begin
            errors++;
            $display("FAIL %s_resp: ready=%b rdata=%h s_valid=%b expected 1 deadbeef 0",
                     tag, mem_ready, mem_rdata, s_valid);
        end
        checks++;
        if (bus_err !== 1'b1 || err_addr !== exp_addr) begin
            errors++;
            $display("FAIL %s_err: bus_err=%b err_addr=%h expected 1 %h", tag, bus_err, err_addr, exp_addr);
        end
        @(negedge clk_cpu);
    endtask

    task automatic pulse_clr();
        @(negedge clk_cpu);
        err_clr = 1'b1;
        @(negedge clk_cpu);
        err_clr = 1'b0;
        checks++;
        if (bus_err !== 1'b0) begin
            errors++;
            $display("FAIL err_clr: bus_err got %b expected 0", bus_err);
        end
    endtask

    task automatic test_unmapped();
        err_req(32'h8000_0000, 1'b0, 32'h8000_0000, "unmapped_first");
        err_req(32'h8100_0000, 1'b0, 32'h8000_0000, "unmapped_second");
        pulse_clr();
        err_req(32'h8300_0000, 1'b0, 32'h8300_0000, "unmapped_after_clr");
        err_req(32'h8200_0000, 1'b1, 32'h8200_0000, "unmapped_with_clr");
        pulse_clr();
    endtask

    task automatic test_timeout();
        int got_n;
        int sv_cnt;
        got_n  = 0;
        sv_cnt = 0;
        start_req(32'h0000_0200, 32'h0, 4'b0000);
`ifdef SOC_BUS_TIMEOUT_EN
        for (int n = 1; n <= 40 && got_n == 0; n++) begin
            @(negedge clk_cpu);
            if (n == 1) mem_valid = 1'b0;
            if (s_valid[0]) sv_cnt++;
            if (mem_ready) got_n = n;
        end
        checks++;
        if (got_n != 17 || sv_cnt != 16) begin
            errors++;
            $display("FAIL timeout_timing: ready at n=%0d after %0d select cycles, expected 17 and 16",
                     got_n, sv_cnt);
        end
        checks++;
        if (mem_rdata !== 32'hDEAD_BEEF || s_valid !== '0) begin
            errors++;
            $display("FAIL timeout_resp: rdata=%h s_valid=%b expected deadbeef 0", mem_rdata, s_valid);
        end
        checks++;
        if (bus_err !== 1'b1 || err_addr !== 32'h0000_0200) begin
            errors++;
            $display("FAIL timeout_err: bus_err=%b err_addr=%h expected 1 00000200", bus_err, err_addr);
        end
        pulse_clr();
`else
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk_cpu);
            if (n == 1) mem_valid = 1'b0;
            if (s_valid[0]) sv_cnt++;
            if (mem_ready) got_n++;
        end
        checks++;
        if (got_n != 0 || sv_cnt != 100 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL stall: ready cycles=%0d select cycles=%0d bus_err=%b expected 0 100 0",
                     got_n, sv_cnt, bus_err);
        end
        apply_reset();
`endif
    endtask

    task automatic test_reset_mid();
        start_req(32'h0000_0300, 32'h0, 4'b0000);
        @(negedge clk_cpu);
        mem_valid = 1'b0;
        @(negedge clk_cpu);
        checks++;
        if (dbg_state !== ACC2 || s_valid !== 6'b000001) begin
            errors++;
            $display("FAIL reset_mid_pre: state=%0d s_valid=%b expected %0d 000001",
                     dbg_state, s_valid, ACC2);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (s_valid !== '0 || mem_ready !== 1'b0 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL reset_mid: s_valid=%b ready=%b state=%0d expected 0 0 %0d",
                     s_valid, mem_ready, dbg_state, IDLE);
        end
        @(negedge clk_cpu);
        reset = 1'b0;
        start_req(32'h0100_0004, 32'h0, 4'b0000);
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk_cpu);
            if (n == 1) mem_valid = 1'b0;
            checks++;
            if (mem_ready !== (n == 3)) begin
                errors++;
                $display("FAIL reset_recover_ready n=%0d: got %b expected %b", n, mem_ready, (n == 3));
            end
        end
        checks++;
        if (mem_rdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL reset_recover_data: got %h expected 12345678", mem_rdata);
        end
    endtask

    initial begin
        reset     = 1'b1;
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        s_ready   = '0;
        err_clr   = 1'b0;
        hs_data   = '0;
        test_reset();
        test_auto_read();
        test_auto_write();
        test_handshake();
        test_unmapped();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/soc_bus_fabric.md
# soc_bus_fabric

Parametrised interconnect between the picorv32 native memory port and N memory-mapped slaves. It replaces hand-written per-slave address compares, ready flops and read-data muxes in the SoC top. The fabric:
- decodes the top address byte(s) and routes the request to one slave;
- supports two slave kinds: fabric-acknowledged slaves (fixed latency) and handshake slaves (slave drives ready);
- returns an error word on unmapped accesses and, optionally, on stalled handshake slaves.

## Interface
Parameters:
- N_SLAVES, 6, number of slave ports.
- DECODE_BITS, 8, number of upper address bits compared per slave.
- SLAVE_BASE, {8'h00,8'h01,8'hf0,8'hfe,8'hff,8'h02}, packed N_SLAVES×DECODE_BITS; slave i matches when mem_addr[31 -: DECODE_BITS] == SLAVE_BASE[i].
- SLAVE_AUTO_ACK, 6'b111110, bit i=1: fabric-acknowledged slave; bit i=0: handshake slave.
- TIMEOUT_CYCLES, 1023, maximum handshake-slave wait; width is $clog2(TIMEOUT_CYCLES+1).

Ports:
- clk_cpu  in  1  CPU clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- mem_valid  in  1  CPU request.
- mem_addr  in  32  CPU address.
- mem_wdata  in  32  CPU write data.
- mem_wstrb  in  4  CPU byte strobes; 0 = read.
- mem_ready  out  1  one-cycle completion pulse.
- mem_rdata  out  32  registered read data; valid while mem_ready=1.
- s_valid  out  N_SLAVES  one-hot slave select.
- s_addr  out  32  latched address.
- s_wdata  out  32  latched write data.
- s_wstrb  out  4  latched strobes, qualified as described in Operation.
- s_rdata  in  N_SLAVES×32  slave read data, slave i at [32i +: 32].
- s_ready  in  N_SLAVES  handshake-slave completion; ignored for auto-ack slaves.
- err_clr  in  1  clears the sticky error state.
- bus_err  out  1  sticky error flag.
- err_addr  out  32  address of the first error since the last clear.

## Operation
State machine with four states: IDLE, ACC1, ACC2, RESP.

IDLE
- When mem_valid=1, latch mem_addr, mem_wdata and mem_wstrb, and latch the one-hot decode.
- Duplicate matches: the lowest index wins.
- No match: go to RESP with mem_rdata=ERR_DATA (32'hDEAD_BEEF) and record the error.
- Match: go to ACC1.

ACC1
- s_valid[sel]=1 and s_wstrb=latched strobes. This is the only cycle in which writes are presented.
- Auto-ack slave: go to ACC2.
- Handshake slave with s_ready[sel]=1: capture s_rdata[sel] and go to RESP.
- Otherwise go to ACC2.

ACC2
- s_valid[sel] stays 1; s_wstrb=0.
- Auto-ack slave: capture s_rdata[sel] at the end of the cycle and go to RESP. This covers synchronous RAMs that need one cycle of read latency.
- Handshake slave: wait for s_ready[sel]. Capture the data on the cycle s_ready[sel]=1, then go to RESP.

RESP
- mem_ready=1 for exactly one cycle; s_valid=0.
- Next state is IDLE. The next request is accepted no earlier than the following cycle.

Error and timing rules:
- s_ready for unselected slaves, or in states other than ACC1/ACC2, is ignored.
- mem_valid dropping mid-transaction does not abort it; the transaction completes.
- bus_err and err_addr are set on the first error. Later errors do not overwrite err_addr until err_clr is asserted.
- If err_clr and a new error occur in the same cycle, the new error wins: bus_err=1 and err_addr takes the new address.
- Reset values: state IDLE; mem_ready=0; mem_rdata=0; s_valid=0; s_addr, s_wdata and s_wstrb=0; bus_err=0; err_addr=0; timeout counter 0.
- Reset asserted mid-transaction forces IDLE immediately, with s_valid=0 and no mem_ready.

## Timing
- Request accepted at edge T.
- Auto-ack slave: s_valid high T+1..T+2; mem_ready at T+3. Total 3 cycles, both reads and writes.
- Handshake slave: mem_ready one cycle after the first s_ready cycle; minimum 2 cycles (s_ready in ACC1).
- Unmapped address: mem_ready at T+1 (reaches RESP directly from IDLE).
- All outputs are registered; no combinational path from mem_* or s_* inputs to any output.

## Configuration
Macro: SOC_BUS_TIMEOUT_EN.
- Defined: a counter runs while a handshake slave is in ACC1/ACC2.
  - It resets on entry to ACC1.
  - When it reaches TIMEOUT_CYCLES without s_ready, the fabric drops s_valid, goes to RESP with ERR_DATA, and records the error.
  - If s_ready arrives in the same cycle the count is reached, s_ready wins.
- Not defined: no counter; handshake slaves can stall indefinitely; only unmapped accesses raise bus_err.

## Structure
- Package soc_bus_pkg holds:
  - the state enum (IDLE, ACC1, ACC2, RESP);
  - ERR_DATA;
  - a function computing the timeout counter width.
- Sub-module soc_bus_decoder: combinational. Inputs are the address and SLAVE_BASE; outputs are the one-hot select and a hit flag, with lowest-index priority.

## Test plan
- Auto-ack read: RAM slave 1 returns 32'h1234_5678 one cycle after select; read at 32'h0100_0010 -> mem_ready at T+3 with mem_rdata=32'h1234_5678; s_wstrb=0 throughout.
- Auto-ack write: write 32'h0000_002A with strobe 4'b0001 to 32'hFF00_0000 -> s_valid[4] high for 2 cycles, s_wstrb=4'b0001 only in ACC1, mem_ready at T+3.
- Handshake read: slave 0 asserts s_ready after 5 cycles with data 32'hCAFE_F00D -> mem_ready exactly one cycle later with that data.
- Unmapped access: read at 32'h8000_0000 -> mem_ready at T+1, mem_rdata=32'hDEAD_BEEF, bus_err=1, err_addr=32'h8000_0000. A second error at 32'h8100_0000 leaves err_addr unchanged; err_clr clears bus_err.
- Timeout (macro defined, TIMEOUT_CYCLES=16): slave 0 never ready -> s_valid drops and mem_ready with 32'hDEAD_BEEF after 16 wait cycles. Without the macro, mem_ready stays low for 100 cycles.
- Reset mid-transaction: assert reset in ACC2 -> s_valid=0 and mem_ready=0 immediately. After release, a new read completes normally.
